// File: rtl/train_track_counter.sv
// -----------------------------------------------------------------------------
// train_track_counter
//   Registered track-section counter for the train controller. Advances on
//   sensor `step` pulses in up, down or shuttle mode, supports a saturating
//   synchronous load and a global clock enable.
//
//   Optional feature macro: TRAIN_DWELL_EN
//     defined   -> shuttle mode pauses DWELL_CYCLES enabled cycles at each end
//                  of the line (DWELL state), then reverses.
//     undefined -> no DWELL state; shuttle mode reverses `dir` on the same edge
//                  that `pos` reaches the end; `dwell` is tied low.
// -----------------------------------------------------------------------------
module train_track_counter #(
  parameter int WIDTH        = 4,
  parameter int MAX_POS      = 9,
  parameter int DWELL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [1:0]       dir_mode,
  input  logic             step,
  output logic [WIDTH-1:0] pos,
  output logic             dir,
  output logic             at_end,
  output logic             dwell,
  output logic             wrap
);

  localparam logic [1:0] MODE_HOLD    = 2'b00;
  localparam logic [1:0] MODE_UP      = 2'b01;
  localparam logic [1:0] MODE_DOWN    = 2'b10;
  localparam logic [1:0] MODE_SHUTTLE = 2'b11;

  // One spare bit so MAX_POS = 2^WIDTH-1 compares and increments cleanly.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_POS);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MOVE  = 2'b01,
    DWELL = 2'b10
  } state_t;

  // Reject illegal configurations at elaboration time.
  if (MAX_POS < 1 || MAX_POS > (2**WIDTH) - 1) begin : g_bad_max_pos
    $error("train_track_counter: MAX_POS out of range");
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("train_track_counter: DWELL_CYCLES must be >= 1");
  end

  state_t state;

  logic [WIDTH:0]   pos_ext;
  logic [WIDTH:0]   up_ext;
  logic [WIDTH:0]   down_ext;
  logic [WIDTH:0]   shuttle_ext;
  logic [WIDTH-1:0] ld_sat;
  logic             at_top;
  logic             at_bot;
  logic             shuttle_up;
  logic             shuttle_lands;

  // Next-position candidates for each mode, all at WIDTH+1 bits.
  // NOTE: every always_comb output gets a value on every path (here all are
  // assigned unconditionally), so no latch can be inferred.
  always_comb begin
    pos_ext     = {1'b0, pos};
    at_top      = (pos_ext == MAX_EXT);
    at_bot      = (pos_ext == '0);
    ld_sat      = ({1'b0, ld_val} > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : ld_val;
    up_ext      = at_top ? '0 : pos_ext + 1'b1;
    down_ext    = at_bot ? MAX_EXT : pos_ext - 1'b1;
    // Already sitting on the end we are heading for: turn round and move away.
    shuttle_up    = dir ? !at_top : at_bot;
    shuttle_ext   = shuttle_up ? pos_ext + 1'b1 : pos_ext - 1'b1;
    shuttle_lands = shuttle_up ? (shuttle_ext == MAX_EXT) : (shuttle_ext == '0);
  end

  // End-of-line flag decoded straight from the registered position.
  assign at_end = at_top || at_bot;

`ifdef TRAIN_DWELL_EN
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  logic [CW-1:0] dwell_cnt;
`else
  assign dwell = 1'b0;
`endif

  // Mode FSM with position, direction, wrap and dwell registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos       <= '0;
      dir       <= 1'b1;
      state     <= IDLE;
      wrap      <= 1'b0;
`ifdef TRAIN_DWELL_EN
      dwell     <= 1'b0;
      dwell_cnt <= '0;
`endif
    end else begin
      wrap <= 1'b0;
      if (en) begin
        if (ld) pos <= ld_sat;

        if (dir_mode == MODE_HOLD) begin
          state <= IDLE;
`ifdef TRAIN_DWELL_EN
          dwell <= 1'b0;
`endif
        end else if (ld) begin
          // A load overrides any step and ends a dwell without reversing.
          state <= MOVE;
`ifdef TRAIN_DWELL_EN
          dwell <= 1'b0;
`endif
        end else begin
          case (state)
            IDLE: state <= MOVE;

            MOVE: begin
              if (step) begin
                case (dir_mode)
                  MODE_UP: begin
                    pos  <= up_ext[WIDTH-1:0];
                    wrap <= at_top;
                    dir  <= 1'b1;
                  end
                  MODE_DOWN: begin
                    pos  <= down_ext[WIDTH-1:0];
                    wrap <= at_bot;
                    dir  <= 1'b0;
                  end
                  default: begin
                    pos <= shuttle_ext[WIDTH-1:0];
`ifdef TRAIN_DWELL_EN
                    dir <= shuttle_up;
                    if (shuttle_lands) begin
                      state     <= DWELL;
                      dwell     <= 1'b1;
                      dwell_cnt <= CW'(DWELL_CYCLES - 1);
                    end
`else
                    dir <= shuttle_up ^ shuttle_lands;
`endif
                  end
                endcase
              end
            end

`ifdef TRAIN_DWELL_EN
            DWELL: begin
              if (dir_mode != MODE_SHUTTLE) begin
                // Leaving shuttle mode aborts the dwell; keep direction.
                state <= MOVE;
                dwell <= 1'b0;
              end else if (dwell_cnt == '0) begin
                state <= MOVE;
                dwell <= 1'b0;
                dir   <= !dir;
              end else begin
                dwell_cnt <= dwell_cnt - 1'b1;
              end
            end
`endif

            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/train_track_counter.md
# train_track_counter

Parametrised position counter for the train controller: tracks the train's track section from sensor `step` pulses and supports load, enable, and up/down/shuttle modes. In shuttle mode it reverses at each end of the line after an optional station dwell. It succeeds the fixed 4-bit combinational next-state/`ld`/`en` counter logic with a registered, generalised block. It sits between the track-sensor conditioning logic and the section/signal decoder.

## Interface
- `WIDTH`, 4, width of position and load value.
- `MAX_POS`, 9, last section index; positions run 0..MAX_POS; must satisfy 1 ≤ MAX_POS ≤ 2^WIDTH−1.
- `DWELL_CYCLES`, 16, station dwell length in enabled cycles; ≥1; used only with `TRAIN_DWELL_EN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  clock enable; when 0, all state is frozen.
- `ld`  in  1  synchronous load of `ld_val`; priority over `step`.
- `ld_val`  in  WIDTH  load value.
- `dir_mode`  in  2  operating mode: 00 hold, 01 up, 10 down, 11 shuttle.
- `step`  in  1  one-cycle advance request from the sensor.
- `pos`  out  WIDTH  current section.
- `dir`  out  1  travel direction; 1 = up.
- `at_end`  out  1  high when `pos` == 0 or `pos` == MAX_POS (decoded from the registered `pos`).
- `dwell`  out  1  high while in the DWELL state.
- `wrap`  out  1  one-cycle pulse on an up/down wrap-around.

## Operation
- Reset (async assert, sync release): `pos`=0, `dir`=1, state=IDLE, dwell count=0, `wrap`=0, `dwell`=0, `at_end`=1.
- States: IDLE (`dir_mode`=00), MOVE, DWELL. Transitions are evaluated only when `en`=1.
  - IDLE→MOVE when `dir_mode`≠00.
  - MOVE/DWELL→IDLE when `dir_mode`=00.
  - DWELL→MOVE when the dwell count is 0, or when `dir_mode` leaves 11 (dwell aborted; `dir` unchanged on abort).
- `ld`=1 with `en`=1:
  - `pos` ← min(`ld_val`, MAX_POS).
  - Any pending `step` is ignored.
  - Loading from DWELL returns the block to MOVE without toggling `dir`.
  - `ld` does not change `dir`.
- `step` in MOVE, no `ld`:
  - Up (01): `pos`+1; at MAX_POS wraps to 0 and pulses `wrap`. `dir` is forced to 1.
  - Down (10): `pos`−1; at 0 wraps to MAX_POS and pulses `wrap`. `dir` is forced to 0.
  - Shuttle (11): moves in direction `dir`. Never wraps.
    - A step that lands on the end in the direction of travel (MAX_POS when `dir`=1, 0 when `dir`=0) enters DWELL, or reverses `dir` (see Configuration).
    - A step requested while already at that end moves away after `dir` reverses. It never moves past the end.
- `step` is ignored in IDLE and DWELL.
- Arithmetic is performed at WIDTH+1 bits, so there is no overflow at MAX_POS = 2^WIDTH−1.

## Timing
- All outputs except `at_end` are registered. Latency from `step` to `pos` is 1 cycle (visible after the next rising edge).
- `wrap` is high for exactly the one cycle following the wrapping edge.
- DWELL:
  - On entry, the dwell count is loaded with DWELL_CYCLES−1 and decrements on each `en`=1 cycle.
  - `dwell` is high for exactly DWELL_CYCLES enabled cycles.
  - On the edge that leaves DWELL, `dir` toggles.
- `en`=0 mid-DWELL pauses the count; the count resumes when `en` returns to 1.
- A `dir_mode` change takes effect on the next enabled edge.
- Reset asserted mid-dwell or mid-move immediately returns the block to the reset values.

## Configuration
- `TRAIN_DWELL_EN` defined: shuttle-end behaviour and DWELL state exactly as described above.
- `TRAIN_DWELL_EN` undefined:
  - The DWELL state and dwell counter are not built, and `dwell` is tied to 0.
  - In shuttle mode, `dir` toggles on the same edge that `pos` reaches the end.
  - `DWELL_CYCLES` is unused.

## Test plan
- Reset then up mode: with MAX_POS=9, 10 `step` pulses → `pos` goes 1..9 then 0. `wrap` pulses once after the 10th step. `at_end` is high at 9 and at 0.
- Down mode from reset: 1 `step` → `pos`=9, `wrap`=1 for one cycle, `dir`=0.
- Load priority: `ld`=1, `ld_val`=12, `step`=1 on the same cycle → `pos`=9 (saturated), no step applied. `ld_val`=3 → `pos`=3.
- Shuttle with dwell (DWELL_CYCLES=4), start at `pos`=7, `dir`=1:
  - 2 steps → `pos`=9 and `dwell` is high for 4 cycles.
  - Steps during dwell are ignored.
  - Then `dir`=0, and the next step gives `pos`=8.
  - Without `TRAIN_DWELL_EN`: `dir`=0 in the same cycle that `pos`=9, and `dwell` stays 0.
- Enable freeze: drop `en` for 5 cycles mid-dwell with `step` pulsing → `pos` and the dwell count are unchanged, and the dwell completes 5 cycles later than it otherwise would.
- Async reset: assert `rst_n`=0 mid-dwell between clock edges → `pos`=0, `dir`=1, `dwell`=0 immediately, without waiting for a clock edge.
